// File: rtl/ysyx_25020047_lsu_ctrl.sv
// Load/store unit: one-outstanding request/response FSM toward a handshaked data-memory port.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module ysyx_25020047_lsu_ctrl #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int STRB  = XLEN / 8;
  localparam int OFF_W = $clog2(STRB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic             lat_we;
  logic             lat_unsigned;
  logic [1:0]       lat_size;
  logic [OFF_W-1:0] lat_off;

  logic [OFF_W-1:0] req_off;
  logic             req_legal;
  logic [3:0]       size_bytes;
  logic [STRB-1:0]  st_mask;
  logic [XLEN-1:0]  st_data;
  logic [6:0]       load_bits;
  logic [XLEN-1:0]  keep_mask;
  logic [XLEN-1:0]  msb_mask;
  logic [XLEN-1:0]  lane;
  logic             load_sign;
  logic [XLEN-1:0]  load_val;
  logic             timeout;

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign mem_req_valid = (state == S_REQ);
  assign req_off       = req_addr[OFF_W-1:0];

  always_comb begin
    case (req_size)
      2'd0:    req_legal = 1'b1;
      2'd1:    req_legal = ~req_addr[0];
      2'd2:    req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = (XLEN == 64) && (req_addr[2:0] == 3'b000);
    endcase
  end

  // Store lanes: a size-wide strobe and data moved up to the byte offset inside the word.
  always_comb begin
    size_bytes = 4'd1 << req_size;
    st_mask    = ~({STRB{1'b1}} << size_bytes) << req_off;
    st_data    = req_wdata << {req_off, 3'b000};
  end

  // Shifts past the datapath width yield zero, so full-width loads get an all-ones keep mask.
  always_comb begin
    load_bits = 7'd8 << lat_size;
    keep_mask = ~({XLEN{1'b1}} << load_bits);
    msb_mask  = keep_mask & ~(keep_mask >> 1);
    lane      = mem_rdata >> {lat_off, 3'b000};
    load_sign = ~lat_unsigned & (|(lane & msb_mask));
    load_val  = (lane & keep_mask) | (load_sign ? ~keep_mask : '0);
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == S_IDLE) begin
      timer <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      timer <= timer + 32'd1;
    end
  end

  assign timeout = (timer >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'd0;
      lat_off      <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_off      <= req_off;
            resp_rdata   <= '0;
            resp_err     <= ~req_legal;
            if (req_legal) begin
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata <= req_we ? st_data : '0;
              mem_wmask <= req_we ? st_mask : '0;
              state     <= S_REQ;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state <= S_WAIT;
          end else if (timeout) begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            resp_rdata <= lat_we ? '0 : load_val;
            state      <= S_RESP;
          end else if (timeout) begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end
        end
        default: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu_ctrl.sv
// Self-checking bench for ysyx_25020047_lsu_ctrl (XLEN=32): directed cases plus randomized
// accesses compared against an arithmetic reference model. Also covers LSU_TIMEOUT_EN when defined.
module tb_ysyx_25020047_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  ysyx_25020047_lsu_ctrl #(
    .XLEN(32),
    .ADDR_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: access rules written as plain byte arithmetic on a 32-bit word.
  function automatic bit refLegal(input int size, input logic [31:0] addr);
    if (size == 3) return 1'b0;
    return (addr % (1 << size)) == 0;
  endfunction

  function automatic logic [31:0] refLoad(input int size, input bit uns, input logic [31:0] addr,
                                          input logic [31:0] word);
    longint unsigned v;
    int nbits;
    nbits = 8 * (1 << size);
    v = (longint'(word) >> (8 * (addr % 4))) % (64'd1 << nbits);
    if (!uns && v >= (64'd1 << (nbits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << nbits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] refWdata(input logic [31:0] addr, input logic [31:0] data);
    longint unsigned v;
    v = longint'(data) << (8 * (addr % 4));
    return v[31:0];
  endfunction

  function automatic logic [3:0] refMask(input int size, input logic [31:0] addr);
    int m;
    m = ((1 << (1 << size)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_mem_req_valid"}, mem_req_valid, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_mem_wmask"}, mem_wmask, 0);
  endtask

  task automatic issueRequest(input bit we, input int size, input bit uns, input logic [31:0] addr,
                              input logic [31:0] wdata);
    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size[1:0];
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  // Full access: request, memory handshake with stalls, memory reply delay, response back-pressure.
  task automatic applyStimulus(input bit we, input int size, input bit uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] word,
                               input int req_stall, input int wait_dly, input int resp_stall);
    logic [31:0] exp_rdata;
    bit legal;
    legal = refLegal(size, addr);
    exp_rdata = (legal && !we) ? refLoad(size, uns, addr, word) : 32'd0;
    issueRequest(we, size, uns, addr, wdata);
    if (!legal) begin
      checkOutput("err_resp_valid", resp_valid, 1);
      checkOutput("err_no_mem_req", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        checkOutput("mem_req_valid", mem_req_valid, 1);
        checkOutput("mem_we", mem_we, we);
        checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("mem_wdata", mem_wdata, we ? refWdata(addr, wdata) : 32'd0);
        checkOutput("mem_wmask", mem_wmask, we ? refMask(size, addr) : 4'd0);
        checkOutput("req_ready_busy", req_ready, 0);
        mem_req_ready = (i == req_stall);
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      checkOutput("mem_req_drop", mem_req_valid, 0);
      for (int i = 0; i <= wait_dly; i++) begin
        checkOutput("no_early_resp", resp_valid, 0);
        mem_resp_valid = (i == wait_dly);
        mem_rdata      = (i == wait_dly) ? word : $urandom;
        @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
    end
    for (int i = 0; i <= resp_stall; i++) begin
      checkOutput("resp_valid", resp_valid, 1);
      checkOutput("resp_err", resp_err, !legal);
      checkOutput("resp_rdata", resp_rdata, exp_rdata);
      checkOutput("mem_req_idle", mem_req_valid, 0);
      resp_ready = (i == resp_stall);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checkOutput("single_resp", resp_valid, 0);
    checkOutput("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int size;
    logic [31:0] addr;

    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(0, 2, 0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 32'h0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h8000_0001, 32'h0000_1234, 32'h0, 0, 0, 0);
    applyStimulus(0, 2, 0, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 3, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(1, 2, 0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 3, 1, 2);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      size = $urandom_range(0, 3);
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      applyStimulus($urandom_range(0, 1), size, $urandom_range(0, 1), addr, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while waiting for memory abandons the access
    issueRequest(0, 2, 0, 32'h8000_0010, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkOutput("rst_pre_wait", mem_req_valid, 0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_no_resp", resp_valid, 0);
      checkOutput("rst_idle", req_ready, 1);
      @(negedge clk);
    end

`ifdef LSU_TIMEOUT_EN
    issueRequest(0, 2, 0, 32'h8000_0020, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      checkOutput("to_no_resp", resp_valid, 0);
      mem_req_ready = (k == 1);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    checkOutput("to_resp_valid", resp_valid, 1);
    checkOutput("to_resp_err", resp_err, 1);
    checkOutput("to_resp_rdata", resp_rdata, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checkOutput("to_late_ignored", resp_valid, 0);
    checkOutput("to_idle", req_ready, 1);
`else
    issueRequest(0, 2, 0, 32'h8000_0020, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("no_to_still_waiting", resp_valid, 0);
    checkOutput("no_to_busy", req_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("no_to_recovered", req_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
